// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared core types and constants used by the fetch stage
package multicore_pkg;

    localparam int INST_SIZE = 32;
    localparam logic [6:0] NOOP_CODE = 7'b0010011;
    localparam logic [INST_SIZE-1:0] NOOP_INSTR = {25'b0, NOOP_CODE};
    localparam logic [INST_SIZE-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HOLD
    } t_fetch_state;

    // Instruction fetches are word aligned, so redirect targets lose their low two bits
    function automatic logic [INST_SIZE-1:0] align_word(input logic [INST_SIZE-1:0] addr);
        return {addr[INST_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-PC selection between sequential, redirect and pending redirect
module fetch_pc_sel
    import multicore_pkg::*;
(
    input  logic [INST_SIZE-1:0] i_pc,
    input  logic                 i_jalr_valid,
    input  logic [INST_SIZE-1:0] i_jalr_addr,
    input  logic                 i_branch_valid,
    input  logic [INST_SIZE-1:0] i_branch_addr,
    input  logic                 i_pend_valid,
    input  logic [INST_SIZE-1:0] i_pend_addr,
    output logic [INST_SIZE-1:0] o_next_pc,
    output logic                 o_redirect
);

    logic [INST_SIZE-1:0] target;

    // Execute redirect is from an older instruction, so it wins over decode;
    // a fresh redirect wins over one still waiting for its killed ack
    always_comb begin
        target     = i_jalr_valid ? i_jalr_addr : i_branch_addr;
        o_redirect = i_jalr_valid | i_branch_valid;
        if (o_redirect) begin
            o_next_pc = align_word(target);
        end else if (i_pend_valid) begin
            o_next_pc = i_pend_addr;
        end else begin
            o_next_pc = i_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC owner, single-outstanding imem req/ack, NOP insertion
module instr_fetch
    import multicore_pkg::*;
#(
    parameter logic [INST_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic                 i_stall,
    input  logic                 i_branch_valid,
    input  logic [INST_SIZE-1:0] i_branch_addr,
    input  logic                 i_jalr_valid,
    input  logic [INST_SIZE-1:0] i_jalr_addr,
    output logic                 o_imem_req,
    output logic [INST_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [INST_SIZE-1:0] i_imem_rdata,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic [INST_SIZE-1:0] o_pc,
    output logic [INST_SIZE-1:0] o_pcplus4
);

    t_fetch_state         state_q, state_d;
    logic [INST_SIZE-1:0] pc_q, pc_d;
    logic [INST_SIZE-1:0] instr_q, instr_d;
    logic [INST_SIZE-1:0] out_pc_q, out_pc_d;
    logic [INST_SIZE-1:0] out_pcplus4_q, out_pcplus4_d;
    logic [INST_SIZE-1:0] hold_instr_q, hold_instr_d;
    logic [INST_SIZE-1:0] hold_pc_q, hold_pc_d;
    logic                 kill_q, kill_d;
    logic [INST_SIZE-1:0] pend_q, pend_d;

    logic [INST_SIZE-1:0] next_pc;
    logic                 redirect;
    logic                 ack;

    fetch_pc_sel u_pc_sel (
        .i_pc           (pc_q),
        .i_jalr_valid   (i_jalr_valid),
        .i_jalr_addr    (i_jalr_addr),
        .i_branch_valid (i_branch_valid),
        .i_branch_addr  (i_branch_addr),
        .i_pend_valid   (kill_q),
        .i_pend_addr    (pend_q),
        .o_next_pc      (next_pc),
        .o_redirect     (redirect)
    );

    // The request address is the PC itself; the PC never moves while a request waits
    assign o_imem_req    = (state_q == S_REQ);
    assign o_imem_addr   = pc_q;
    assign ack           = i_imem_ack & o_imem_req;
    assign o_instruction = instr_q;
    assign o_pc          = out_pc_q;
    assign o_pcplus4     = out_pcplus4_q;

    // Fetch sequencing: delivery, stall capture, redirect and kill handling
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        out_pc_d      = out_pc_q;
        out_pcplus4_d = out_pcplus4_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        kill_d        = kill_q;
        pend_d        = pend_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                instr_d = NOOP_INSTR;
                if (redirect) begin
                    pc_d = next_pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    instr_d = NOOP_INSTR;
                    if (ack) begin
                        // Wrong-path word is dropped and the new target fetched next
                        pc_d   = next_pc;
                        kill_d = 1'b0;
                    end else begin
                        // Address must stay put until the ack, so park the target
                        kill_d = 1'b1;
                        pend_d = next_pc;
                    end
                end else if (ack && kill_q) begin
                    pc_d   = next_pc;
                    kill_d = 1'b0;
                    if (!i_stall) begin
                        instr_d = NOOP_INSTR;
                    end
                end else if (ack && i_stall) begin
                    hold_instr_d = i_imem_rdata;
                    hold_pc_d    = pc_q;
                    pc_d         = next_pc;
                    state_d      = S_HOLD;
                end else if (ack) begin
                    instr_d       = i_imem_rdata;
                    out_pc_d      = pc_q;
                    out_pcplus4_d = pc_q + PC_STEP;
                    pc_d          = next_pc;
                end else if (!i_stall) begin
                    instr_d = NOOP_INSTR;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    instr_d = NOOP_INSTR;
                    state_d = S_REQ;
                end else if (!i_stall) begin
                    instr_d       = hold_instr_q;
                    out_pc_d      = hold_pc_q;
                    out_pcplus4_d = hold_pc_q + PC_STEP;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and output registers, asynchronously returned to the boot image
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOOP_INSTR;
            out_pc_q      <= RESET_PC;
            out_pcplus4_q <= RESET_PC + PC_STEP;
            hold_instr_q  <= NOOP_INSTR;
            hold_pc_q     <= RESET_PC;
            kill_q        <= 1'b0;
            pend_q        <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            out_pc_q      <= out_pc_d;
            out_pcplus4_q <= out_pcplus4_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            kill_q        <= kill_d;
            pend_q        <= pend_d;
        end
    end

endmodule
